morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side counterpart of the Morse transmitter core. It samples a serial on/off keying line such as `morse_out`, measures mark and space durations in prescaler-defined time units, and classifies each as dot, dash or gap. It decodes each completed element sequence to one ASCII byte and delivers it through a small FIFO on a valid/ready stream. It sits downstream of the transmitter: in loopback benches it is wired directly to `morse_out`, and in systems it feeds an AXI4-Lite read wrapper.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, ≥2.
- `MAX_ELEMS`, default 6: maximum elements per character.
- `aclk` input, 1 bit: sole clock, rising edge.
- `aresetn` input, 1 bit: asynchronous active-low reset.
- `prescaler` input, 32 bits: one unit = `prescaler`+1 `aclk` cycles; same encoding as the transmitter.
- `morse_in` input, 1 bit: keyed line, 1 = mark; asynchronous to `aclk`.
- `ascii_out` output, 8 bits: head of FIFO; reset 0x00.
- `ascii_valid` output, 1 bit: FIFO non-empty; reset 0.
- `ascii_ready` input, 1 bit: consumer accepts `ascii_out` when `ascii_valid`&`ascii_ready`.
- `overrun` output, 1 bit: 1-cycle pulse when a decoded byte is dropped because the FIFO is full; reset 0.
- `code_err` output, 1 bit: 1-cycle pulse when a 0x3F is pushed for an invalid code; reset 0.

## Operation
- Input path:
  - `morse_in` passes through a 2-flop synchronizer; a third flop provides edge detection.
  - All timing below refers to the synchronized signal `s`.
- Unit timer:
  - Counts 0..`prescaler`. Wrapping produces `tick`.
  - Clears to 0 on every edge of `s`.
  - `prescaler` is compared live, so a change takes effect within the current unit.
- Run counter `run_units`, 3 bits:
  - Clears on each `s` edge.
  - Increments on `tick`, saturating at 7.
- Code register:
  - 7 bits, initialised to sentinel 0000001.
  - Each element shifts in from the LSB: dot = 0, dash = 1.
  - `elem_cnt` counts elements, 0..`MAX_ELEMS`+1 (saturating).
- State machine `IDLE`, `MARK`, `SPACE`:
  - `IDLE`: reset state, and the state after a word gap. Rising edge of `s` → `MARK`.
  - `MARK`, on falling edge of `s`:
    - `run_units` ≤1 → dot; ≥2 → dash.
    - Shift into the code register, increment `elem_cnt`, → `SPACE`.
  - `SPACE` while low:
    - `run_units` reaches 2 with `elem_cnt`>0 → push decoded byte, clear code, set `space_armed`.
    - `run_units` reaches 5 with `space_armed` → push 0x20, clear `space_armed`, → `IDLE`.
  - `SPACE`, rising edge before 2 units (intra-character gap) → `MARK`.
  - `SPACE`, rising edge after a letter gap → `MARK`.
- Decoding:
  - International Morse table covering A–Z (output uppercase), 0–9 and `. , ? / = -`, via a package function.
  - Unknown code, or `elem_cnt` > `MAX_ELEMS` → push 0x3F and pulse `code_err`.
  - Extra elements beyond `MAX_ELEMS` do not shift into the code register.
- Push rules:
  - Push while the FIFO is full → byte dropped, `overrun` pulses, FIFO contents untouched.
  - Simultaneous push and pop on a full FIFO → pop first, push succeeds, no `overrun`.
- Reset at any time:
  - Clears synchronizer, counters, code register, `space_armed` and FIFO.
  - Outputs return to reset values; any partial character is discarded.
- After reset, `space_armed`=0: a line idle from reset never produces a space.

## Timing
- Synchronizer latency: 2 cycles from `morse_in` to `s`; edge detection adds 1.
- The letter-gap push occurs in the cycle the second `tick` of the low run registers. `ascii_valid` rises the following cycle if the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through; `ascii_out` is stable while `ascii_valid`&!`ascii_ready`.
  - Pop on handshake; the next entry is visible the next cycle.
- Mark shorter than 1 unit → still a dot. There is no glitch filter beyond synchronization.
- A mark longer than 7 units saturates and is classified as a dash.

## Structure
- Package `morse_pkg`:
  - Thresholds DASH_MIN_UNITS=2, LETTER_GAP_UNITS=2, WORD_GAP_UNITS=5.
  - Sentinel code constant, state enum, function `code_to_ascii(code[6:0])` returning 8 bits (0x3F on miss).
  - The transmitter shares the same table.
- Sub-module `morse_sync_fifo`: single-clock FIFO with parameter DEPTH, first-word fall-through, full/empty flags, asynchronous active-low reset.

## Test plan
- `prescaler`=3 (4-cycle unit); mark 4 cycles, then low 40 cycles → single byte 0x45 ('E'), then single byte 0x20, no `code_err`.
- "SOS" keyed at `prescaler`=3 with 3-unit letter gaps → bytes 0x53, 0x4F, 0x53 in order; 0x20 after 5 units idle.
- "A B" with a 7-unit word gap, `ascii_ready`=1 → 0x41, 0x20, 0x42; no space before 'A' after reset.
- Eight dots then a letter gap → 0x3F with a 1-cycle `code_err`; the next character decodes correctly.
- `ascii_ready`=0, five 'E's keyed → 4 entries held, `overrun` pulses once on the fifth push; draining yields four 0x45.
- Reset asserted mid-dash of 'A', released, then 'T' keyed → only 0x54 emitted; all outputs 0 during reset.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse timing thresholds, FSM states and code-to-ASCII table
// Codes hold a leading sentinel 1 followed by elements MSB-first (dot=0, dash=1).
package morse_pkg;
    localparam int DASH_MIN_UNITS   = 2;
    localparam int LETTER_GAP_UNITS = 2;
    localparam int WORD_GAP_UNITS   = 5;
    localparam logic [6:0] CODE_SENTINEL = 7'b0000001;
    // '?' legitimately decodes to 0x3F, so it must be told apart from a miss
    localparam logic [6:0] CODE_QMARK    = 7'b1001100;
    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
    function automatic logic [7:0] code_to_ascii(input logic [6:0] code);
        case (code)
            7'b0000101: code_to_ascii = "A";
            7'b0011000: code_to_ascii = "B";
            7'b0011010: code_to_ascii = "C";
            7'b0001100: code_to_ascii = "D";
            7'b0000010: code_to_ascii = "E";
            7'b0010010: code_to_ascii = "F";
            7'b0001110: code_to_ascii = "G";
            7'b0010000: code_to_ascii = "H";
            7'b0000100: code_to_ascii = "I";
            7'b0010111: code_to_ascii = "J";
            7'b0001101: code_to_ascii = "K";
            7'b0010100: code_to_ascii = "L";
            7'b0000111: code_to_ascii = "M";
            7'b0000110: code_to_ascii = "N";
            7'b0001111: code_to_ascii = "O";
            7'b0010110: code_to_ascii = "P";
            7'b0011101: code_to_ascii = "Q";
            7'b0001010: code_to_ascii = "R";
            7'b0001000: code_to_ascii = "S";
            7'b0000011: code_to_ascii = "T";
            7'b0001001: code_to_ascii = "U";
            7'b0010001: code_to_ascii = "V";
            7'b0001011: code_to_ascii = "W";
            7'b0011001: code_to_ascii = "X";
            7'b0011011: code_to_ascii = "Y";
            7'b0011100: code_to_ascii = "Z";
            7'b0111111: code_to_ascii = "0";
            7'b0101111: code_to_ascii = "1";
            7'b0100111: code_to_ascii = "2";
            7'b0100011: code_to_ascii = "3";
            7'b0100001: code_to_ascii = "4";
            7'b0100000: code_to_ascii = "5";
            7'b0110000: code_to_ascii = "6";
            7'b0111000: code_to_ascii = "7";
            7'b0111100: code_to_ascii = "8";
            7'b0111110: code_to_ascii = "9";
            7'b1010101: code_to_ascii = ".";
            7'b1110011: code_to_ascii = ",";
            7'b1001100: code_to_ascii = "?";
            7'b0110010: code_to_ascii = "/";
            7'b0110001: code_to_ascii = "=";
            7'b1100001: code_to_ascii = "-";
            default:    code_to_ascii = 8'h3F;
        endcase
    endfunction
endpackage

// File: rtl/morse_sync_fifo.sv
// morse_sync_fifo: single-clock first-word fall-through FIFO
// Ports: i_clk, i_rst_n (async active-low), i_push/i_data write side,
// i_pop read side, o_data head entry (0 when empty), o_full, o_empty.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module morse_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0] r_count;
    logic w_push, w_pop;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wr] <= i_data;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: on/off keyed Morse receiver producing an ASCII valid/ready stream
// Ports: aclk, aresetn (async active-low), prescaler (unit = prescaler+1 cycles),
// morse_in (async keyed line), ascii_out/ascii_valid/ascii_ready output stream,
// overrun (byte dropped on full FIFO), code_err (0x3F pushed for an invalid code).
module morse_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_ELEMS  = 6
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] prescaler,
    input  logic        morse_in,
    output logic [7:0]  ascii_out,
    output logic        ascii_valid,
    input  logic        ascii_ready,
    output logic        overrun,
    output logic        code_err
);
    import morse_pkg::*;
    localparam int EW = $clog2(MAX_ELEMS + 2);
    logic r_sync1, r_s, r_s_d, r_armed, r_overrun, r_code_err;
    logic [31:0] r_unit;
    logic [2:0] r_run;
    logic [6:0] r_code;
    logic [EW-1:0] r_elem;
    state_t r_state, w_next;
    logic w_rise, w_fall, w_edge, w_tick, w_dash, w_invalid;
    logic w_shift, w_push_letter, w_push_space, w_push, w_full, w_empty;
    logic [7:0] w_letter, w_push_data;
    assign w_rise = r_s && !r_s_d;
    assign w_fall = !r_s && r_s_d;
    assign w_edge = w_rise || w_fall;
    // >= rather than == so a lowered prescaler wraps at once instead of running to 2^32
    assign w_tick = !w_edge && (r_unit >= prescaler);
    assign w_dash = r_run >= 3'(DASH_MIN_UNITS);
    assign w_invalid = (r_elem > EW'(MAX_ELEMS)) ||
                       (code_to_ascii(r_code) == 8'h3F && r_code != CODE_QMARK);
    assign w_letter = w_invalid ? 8'h3F : code_to_ascii(r_code);
    assign w_push = w_push_letter || w_push_space;
    assign w_push_data = w_push_space ? 8'h20 : w_letter;
    assign ascii_valid = !w_empty;
    assign overrun = r_overrun;
    assign code_err = r_code_err;
    // Gap pushes fire on the tick that carries run_units up to the threshold
    always_comb begin
        w_next = r_state;
        w_shift = 1'b0;
        w_push_letter = 1'b0;
        w_push_space = 1'b0;
        case (r_state)
            IDLE: w_next = w_rise ? MARK : IDLE;
            MARK: begin
                w_shift = w_fall;
                w_next = w_fall ? SPACE : MARK;
            end
            SPACE: begin
                w_push_letter = !w_rise && w_tick && r_run == 3'(LETTER_GAP_UNITS - 1) && r_elem != '0;
                w_push_space = !w_rise && w_tick && r_run == 3'(WORD_GAP_UNITS - 1) && r_armed;
                w_next = w_rise ? MARK : w_push_space ? IDLE : SPACE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) r_state <= IDLE;
        else r_state <= w_next;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            r_sync1    <= 1'b0;
            r_s        <= 1'b0;
            r_s_d      <= 1'b0;
            r_unit     <= '0;
            r_run      <= '0;
            r_code     <= CODE_SENTINEL;
            r_elem     <= '0;
            r_armed    <= 1'b0;
            r_overrun  <= 1'b0;
            r_code_err <= 1'b0;
        end else begin
            r_sync1 <= morse_in;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
            r_unit  <= (w_edge || r_unit >= prescaler) ? '0 : r_unit + 32'd1;
            r_run   <= w_edge ? '0 : (w_tick && r_run != 3'd7) ? r_run + 3'd1 : r_run;
            if (w_shift) begin
                if (r_elem < EW'(MAX_ELEMS)) r_code <= {r_code[5:0], w_dash};
                if (r_elem != EW'(MAX_ELEMS + 1)) r_elem <= r_elem + 1'b1;
            end else if (w_push_letter) begin
                r_code <= CODE_SENTINEL;
                r_elem <= '0;
            end
            r_armed    <= w_push_letter ? 1'b1 : w_push_space ? 1'b0 : r_armed;
            r_overrun  <= w_push && w_full && !ascii_ready;
            r_code_err <= w_push_letter && w_invalid;
        end
    morse_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (ascii_ready),
        .o_data  (ascii_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: keys text onto morse_in and checks the decoded byte stream
module tb_morse_decoder;
    logic aclk = 0, aresetn, morse_in, ascii_ready, ascii_valid, overrun, code_err;
    logic [31:0] prescaler;
    logic [7:0] ascii_out;
    int checks = 0, errors = 0, ce_cnt = 0, ov_cnt = 0, ce0, ov0;
    bit jit;
    byte q_rx[$];
    string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.,?/=-";
    string pats[42] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---",
                        "...--", "....-", ".....", "-....", "--...", "---..", "----.",
                        ".-.-.-", "--..--", "..--..", "-..-.", "-...-", "-....-"};

    morse_decoder dut (
        .aclk(aclk), .aresetn(aresetn), .prescaler(prescaler), .morse_in(morse_in),
        .ascii_out(ascii_out), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
        .overrun(overrun), .code_err(code_err)
    );

    always #5 aclk = ~aclk;

    // Outputs are sampled on the falling edge; a valid&ready seen here pops on the next rise
    always @(negedge aclk)
        if (aresetn === 1'b1) begin
            if (ascii_valid && ascii_ready) q_rx.push_back(ascii_out);
            if (code_err) ce_cnt++;
            if (overrun) ov_cnt++;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        morse_in = v;
        repeat (n) @(posedge aclk);
        #2;
    endtask

    function automatic string pat_of(input byte c);
        for (int i = 0; i < chars.len(); i++)
            if (chars[i] == c) return pats[i];
        return "";
    endfunction

    function automatic int jr(input int base, input int span);
        return base + (jit && span > 0 ? int'($urandom_range(span, 0)) : 0);
    endfunction

    // Timing rules: dot < 2 units, dash >= 2, intra gap < 2, letter gap 2..4, word gap >= 5
    task automatic send_text(input string txt);
        int u;
        string p;
        byte nxt;
        u = int'(prescaler) + 1;
        for (int i = 0; i < txt.len(); i++) begin
            if (txt[i] == " ") continue;
            p = pat_of(txt[i]);
            for (int j = 0; j < p.len(); j++) begin
                hold(1'b1, p[j] == "-" ? jr(3 * u, u) : jr(u, u - 2));
                if (j < p.len() - 1) hold(1'b0, jr(u, u - 2));
            end
            nxt = (i + 1 < txt.len()) ? txt[i + 1] : " ";
            hold(1'b0, nxt == " " ? jr(7 * u, u) : jr(3 * u, u - 1));
        end
    endtask

    task automatic expect_str(input string tag, input string exp, input int budget);
        int k = 0;
        while (q_rx.size() < exp.len() && k < budget) begin
            @(posedge aclk);
            k++;
        end
        #2;
        chk({tag, "_count"}, q_rx.size(), exp.len());
        for (int i = 0; i < exp.len() && q_rx.size() > 0; i++)
            chk($sformatf("%s_byte%0d", tag, i), q_rx.pop_front(), exp[i]);
        q_rx.delete();
    endtask

    initial begin
        string txt;
        aresetn = 0; morse_in = 0; ascii_ready = 1; prescaler = 3; jit = 0;
        repeat (5) @(posedge aclk);
        #2;
        chk("rst_valid", ascii_valid, 0);
        chk("rst_data", ascii_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_code_err", code_err, 0);
        aresetn = 1;
        hold(1'b0, 60);
        chk("idle_no_space", q_rx.size(), 0);

        ce0 = ce_cnt;
        hold(1'b1, 4);
        hold(1'b0, 40);
        expect_str("e", "E ", 100);
        chk("e_code_err", ce_cnt - ce0, 0);

        send_text("SOS");
        expect_str("sos", "SOS ", 200);

        send_text("A B");
        expect_str("ab", "A B ", 200);

        ce0 = ce_cnt;
        for (int k = 0; k < 8; k++) begin
            hold(1'b1, 4);
            hold(1'b0, k < 7 ? 4 : 12);
        end
        send_text("E");
        expect_str("eight_dots", "?E ", 200);
        chk("eight_dots_code_err", ce_cnt - ce0, 1);

        ascii_ready = 0;
        ov0 = ov_cnt;
        for (int k = 0; k < 4; k++) begin
            hold(1'b1, 4);
            hold(1'b0, 12);
        end
        chk("full_no_overrun", ov_cnt - ov0, 0);
        hold(1'b1, 4);
        hold(1'b0, 14);
        chk("overrun_once", ov_cnt - ov0, 1);
        chk("held_valid", ascii_valid, 1);
        chk("held_data", ascii_out, 8'h45);
        ascii_ready = 1;
        expect_str("drain", "EEEE ", 200);
        chk("overrun_after_drain", ov_cnt - ov0, 1);

        ascii_ready = 0;
        hold(1'b1, 4);
        hold(1'b0, 12);
        chk("pre_reset_valid", ascii_valid, 1);
        hold(1'b1, 4);
        hold(1'b0, 4);
        hold(1'b1, 6);
        aresetn = 0;
        morse_in = 0;
        repeat (3) @(posedge aclk);
        #2;
        chk("mid_rst_valid", ascii_valid, 0);
        chk("mid_rst_data", ascii_out, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_code_err", code_err, 0);
        aresetn = 1;
        ascii_ready = 1;
        q_rx.delete();
        hold(1'b0, 20);
        send_text("T");
        expect_str("after_rst", "T ", 200);

        jit = 1;
        for (int r = 0; r < 4; r++) begin
            prescaler = $urandom_range(4, 1);
            txt = "";
            for (int k = 0; k < 8; k++) begin
                if (k > 0 && $urandom_range(3, 0) == 0) txt = {txt, " "};
                txt = $sformatf("%s%c", txt, chars[$urandom_range(chars.len() - 1, 0)]);
            end
            ce0 = ce_cnt;
            send_text(txt);
            expect_str($sformatf("rand%0d", r), {txt, " "}, 400);
            chk($sformatf("rand%0d_code_err", r), ce_cnt - ce0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
